// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial-sensor sequencer: FSM states,
// the power-up register writes and the burst-read address map.
package inert_pkg;

    typedef enum logic [2:0] {
        POR_WAIT = 3'd0,
        INIT     = 3'd1,
        WAIT_INT = 3'd2,
        READ     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int N_INIT  = 4;
    localparam int N_BYTES = 8;

    // Configuration writes issued once after the sensor has settled
    localparam logic [15:0] INIT_CMD [0:N_INIT-1] = '{
        16'h0D02, 16'h1053, 16'h1150, 16'h1460
    };

    // Low byte first for each axis: roll, yaw, AY, AZ
    localparam logic [6:0] RD_ADDR [0:N_BYTES-1] = '{
        7'h24, 7'h25, 7'h26, 7'h27, 7'h2A, 7'h2B, 7'h2C, 7'h2D
    };

    localparam logic READ_BIT = 1'b1;

    function automatic logic [15:0] rd_cmd(input logic [2:0] b);
        return {READ_BIT, RD_ADDR[b], 8'h00};
    endfunction

endpackage

// File: rtl/inert_sync2.sv
// Two-flop synchronizer for asynchronous sensor inputs; W independent bits.
module inert_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/inert_seq.sv
// Inertial sensor sequencer: power-on wait, register init, then INT-driven
// 8-byte burst reads published atomically as four signed 16-bit words.
module inert_seq
    import inert_pkg::*;
#(
    parameter int POR_W    = 16,
    parameter int SIM_FAST = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        spi_done,
    input  logic [7:0]  spi_rd_data,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic        vld,
    output logic [15:0] roll_rt,
    output logic [15:0] yaw_rt,
    output logic [15:0] AY,
    output logic [15:0] AZ
);

    state_t             r_state;
    logic [POR_W-1:0]   r_por_cnt;
    logic [1:0]         r_init_idx;
    logic [2:0]         r_byte_idx;
    logic               r_pend;
    logic [7:0]         r_shadow [0:N_BYTES-2];
    logic [15:0]        r_roll;
    logic [15:0]        r_yaw;
    logic [15:0]        r_ay;
    logic [15:0]        r_az;

    logic               w_int_s;
    logic               w_por_done;
    logic               w_issue;
    logic               w_xfer_done;
    logic [15:0]        w_cmd;

    inert_sync2 #(.W(1)) u_int_sync (
        .clk (clk),
        .rst (rst),
        .i_d (INT),
        .o_q (w_int_s)
    );

    assign w_por_done = (SIM_FAST != 0) ? (r_por_cnt[3:0] == 4'hF) : (&r_por_cnt);

    // A command goes out only when nothing is outstanding; a done pulse with
    // nothing outstanding (including the issue cycle itself) is dropped.
    assign w_issue     = ((r_state == INIT) || (r_state == READ)) && !r_pend;
    assign w_xfer_done = spi_done && r_pend;

    always_comb begin
        w_cmd = 16'h0000;
        case (r_state)
            INIT:    w_cmd = INIT_CMD[r_init_idx];
            READ:    w_cmd = rd_cmd(r_byte_idx);
            default: w_cmd = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else if (w_issue) begin
            r_pend <= 1'b1;
        end else if (w_xfer_done) begin
            r_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= POR_WAIT;
            r_por_cnt  <= '0;
            r_init_idx <= 2'd0;
            r_byte_idx <= 3'd0;
            r_roll     <= 16'h0000;
            r_yaw      <= 16'h0000;
            r_ay       <= 16'h0000;
            r_az       <= 16'h0000;
        end else begin
            case (r_state)
                POR_WAIT: begin
                    r_por_cnt <= r_por_cnt + POR_W'(1);
                    if (w_por_done) begin
                        r_state    <= INIT;
                        r_init_idx <= 2'd0;
                    end
                end
                INIT: begin
                    if (w_xfer_done) begin
                        r_init_idx <= r_init_idx + 2'd1;
                        if (r_init_idx == 2'd3) begin
                            r_state <= WAIT_INT;
                        end
                    end
                end
                WAIT_INT: begin
                    if (w_int_s) begin
                        r_state    <= READ;
                        r_byte_idx <= 3'd0;
                    end
                end
                READ: begin
                    if (w_xfer_done) begin
                        r_byte_idx <= r_byte_idx + 3'd1;
                        // Last byte: publish all four words together from the shadow
                        if (r_byte_idx == 3'd7) begin
                            r_roll  <= {r_shadow[1], r_shadow[0]};
                            r_yaw   <= {r_shadow[3], r_shadow[2]};
                            r_ay    <= {r_shadow[5], r_shadow[4]};
                            r_az    <= {spi_rd_data, r_shadow[6]};
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= WAIT_INT;
                end
                default: begin
                    r_state <= POR_WAIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_BYTES - 1; k++) begin
                r_shadow[k] <= 8'h00;
            end
        end else if ((r_state == READ) && w_xfer_done && (r_byte_idx != 3'd7)) begin
            r_shadow[r_byte_idx] <= spi_rd_data;
        end
    end

    assign spi_wrt = w_issue;
    assign spi_cmd = w_cmd;
    assign vld     = (r_state == DONE);
    assign roll_rt = r_roll;
    assign yaw_rt  = r_yaw;
    assign AY      = r_ay;
    assign AZ      = r_az;

endmodule
